// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: two-requester round-robin arbiter driving the shared 2:1 mux select.
// Define MUX_ARB_GAP_EN to insert a one-cycle break-before-make GAP state on every handover.
module mux_share_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    output logic [1:0]       grant,
    output logic             sel,
    output logic             busy,
    output logic             preempt,
    output logic [CNT_W-1:0] hold_cnt
);
`ifdef MUX_ARB_GAP_EN
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);
    state_t state, state_n;
    logic [1:0] grant_n;
    logic [CNT_W-1:0] cnt_n;
    logic last, last_n, sel_n, pre_n, cur, mine, other, expired, pick;
    always_comb begin
        cur = state == OWN1;
        mine = req[cur];
        other = req[~cur];
        expired = hold_cnt == CNT_MAX;
        pick = (req == 2'b11) ? ~last : req[1];
        state_n = state;
        sel_n = sel;
        last_n = last;
        pre_n = 1'b0;
        cnt_n = '0;
        case (state)
            IDLE: if (req != 2'b00) begin
                state_n = pick ? OWN1 : OWN0;
                sel_n = pick;
                last_n = pick;
            end
            OWN0, OWN1: if (other && (!mine || expired)) begin
                pre_n = mine;
                sel_n = ~cur;
`ifdef MUX_ARB_GAP_EN
                state_n = GAP;
`else
                state_n = cur ? OWN0 : OWN1;
                last_n = ~cur;
`endif
            end else if (!mine) begin
                state_n = IDLE;
            end else begin
                cnt_n = expired ? hold_cnt : hold_cnt + 1'b1;
            end
`ifdef MUX_ARB_GAP_EN
            // sel already points at the incoming owner
            default: begin
                state_n = sel ? OWN1 : OWN0;
                last_n = sel;
            end
`else
            default: state_n = IDLE;
`endif
        endcase
        grant_n = {state_n == OWN1, state_n == OWN0};
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= 2'b00;
            sel <= 1'b0;
            preempt <= 1'b0;
            hold_cnt <= '0;
            last <= 1'b1;
        end else begin
            state <= state_n;
            grant <= grant_n;
            sel <= sel_n;
            preempt <= pre_n;
            hold_cnt <= cnt_n;
            last <= last_n;
        end
    end
    assign busy = |grant;
endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
- Two-requester round-robin arbiter that owns the select line of the shared 2:1 mux datapath (the s input of mux2to1).
- Grants one requester at a time and holds the grant until release.
- Forces a handover after HOLD_MAX cycles when the other requester is waiting.
- Sits between requesting lab modules and the mux/7400-series select wire.

Parameters:
- HOLD_MAX, 4: maximum consecutive grant cycles while the other requester waits. Legal range is 1..2^CNT_W-1.
- CNT_W, 8: width of the hold counter.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  2  req[0] = requester on mux input x, req[1] = requester on mux input y. Level: held high while the resource is wanted.
- grant  output  2  one-hot or zero. grant[i] = requester i owns the mux.
- sel  output  1  drives mux s. 0 selects x (req 0), 1 selects y (req 1).
- busy  output  1  OR of grant.
- preempt  output  1  one-cycle pulse on a forced handover.
- hold_cnt  output  CNT_W  cycles the current owner has held the grant.

Behaviour:
- Reset (async, immediate): state IDLE, grant=00, sel=0, busy=0, preempt=0, hold_cnt=0, last=1 (req 0 wins the first tie).
- All outputs are registered. A req sampled at edge N produces a grant visible after edge N (latency 1). Releases behave the same way.
- States: IDLE, OWN0, OWN1 (plus GAP when MUX_ARB_GAP_EN is defined). 2-bit encoding.
- IDLE:
  - req=00: stay.
  - req=01: go to OWN0.
  - req=10: go to OWN1.
  - req=11: grant the requester not equal to last.
  - sel holds its previous value in IDLE (no datapath toggle).
- OWNi:
  - grant[i]=1, sel=i.
  - hold_cnt starts at 0 on entry and increments each cycle, saturating at HOLD_MAX-1.
- OWNi transitions, in priority order:
  - req[i]=0 and req[j]=1: go to OWNj, preempt=0.
  - req[i]=0 and req[j]=0: go to IDLE.
  - req[i]=1, req[j]=1 and hold_cnt==HOLD_MAX-1: go to OWNj, preempt=1 for exactly one cycle.
  - Otherwise stay.
- last is updated to i on every entry into OWNi.
- With HOLD_MAX=1 and both requesters held, the grant alternates every cycle.
- Simultaneous release by the owner and a new request from the other requester: direct handover, no IDLE cycle.
- grant is never 11. sel never changes while grant is held by the same owner.
- Reset asserted mid-grant: grant drops in the same cycle (async). Arbitration restarts from the reset state.

Optional Feature:
- Macro: MUX_ARB_GAP_EN.
- Defined:
  - Every OWNi-to-OWNj handover passes through GAP for one cycle.
  - During GAP: grant=00, busy=0, sel already equals j (break-before-make, lets the mux output settle).
  - preempt pulses during the GAP cycle when the handover is forced.
  - GAP always proceeds to OWNj, even if req[j] has dropped; OWNj then releases to IDLE on the next edge.
  - hold_cnt=0 in GAP.
- Undefined: handover is direct. sel and grant change on the same edge. GAP does not exist.

Test Plan:
- Reset then req=11 held, HOLD_MAX=4: grant=01 after the first edge. hold_cnt 0,1,2,3. grant=10 with preempt=1 for one cycle, sel=1. Grants alternate every 4 cycles while both are held.
- req=01 for 3 cycles then 00: grant=01, sel=0 for 3 cycles. grant=00, busy=0 one edge after release. sel stays 0.
- OWN1 with hold_cnt=1: drop req[1] while req[0]=1 → grant=01 next edge, preempt=0, hold_cnt=0.
- req=10 then 00, then req=11: OWN1 first, then OWN0 granted (last=1), sel goes 1→0.
- Assert reset asynchronously mid-OWN1 → grant=00, sel=0 before the next edge. After release of reset with req=11 → grant=01.
- With MUX_ARB_GAP_EN defined, forced handover 0→1: one cycle grant=00, sel=1, preempt=1, then grant=10.
